// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding, the NOP word and the PC step.
// Imported by the PC/FSM top and by the IF/ID register.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Clear (bubble) wins over hold; otherwise the register loads every cycle.
module ifid_reg
  import pc_fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (i_clear) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (!i_hold) begin
      instr_d    = i_instr;
      pc_plus4_d = i_pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc_plus4 = pc_plus4_q;
  assign o_valid    = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register, boot delay and BOOT/RUN/HALT control for the fetch stage.
// The next-PC mux is external: we export PC+4 and consume its selected output.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_next_pc,
  input  logic [31:0] i_instr,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc_plus4,
  output logic        o_ifid_valid,
  output logic        o_misalign
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [3:0]   boot_cnt_q, boot_cnt_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic         ifid_hold, ifid_clear;
  logic         pc_update;
  logic [31:0]  pc_plus4;

  assign pc_plus4  = pc_q + PC_INCR;
  assign pc_update = i_flush || !i_stall;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        ifid_clear = 1'b1;
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A rejected target halts the stage; only reset recovers it.
        if (pc_update && !is_word_aligned(i_next_pc)) begin
          ifid_clear = 1'b1;
          misalign_d = 1'b1;
          state_d    = ST_HALT;
        end else if (i_flush) begin
          pc_d       = i_next_pc;
          ifid_clear = 1'b1;
        end else if (i_stall) begin
          ifid_hold  = 1'b1;
        end else begin
          pc_d       = i_next_pc;
        end
      end
      ST_HALT: begin
        ifid_clear = 1'b1;
      end
      default: begin
        ifid_clear = 1'b1;
        state_d    = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 4'd0;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  ifid_reg u_ifid_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_hold     (ifid_hold),
    .i_clear    (ifid_clear),
    .i_instr    (i_instr),
    .i_pc_plus4 (pc_plus4),
    .o_instr    (o_ifid_instr),
    .o_pc_plus4 (o_ifid_pc_plus4),
    .o_valid    (o_ifid_valid)
  );

  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: vector table for the RUN sequence plus
// hand-written boot, halt/reset and wrap-around sequences.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] next_pc, instr;
  logic [31:0] pc, pc_plus4, ifid_instr, ifid_pp4;
  logic        ifid_valid, misalign;

  logic        w_rst, w_stall, w_flush;
  logic [31:0] w_next_pc, w_instr;
  logic [31:0] w_pc, w_pc_plus4, w_ifid_instr, w_ifid_pp4;
  logic        w_ifid_valid, w_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .BOOT_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_next_pc(next_pc), .i_instr(instr),
    .i_stall(stall), .i_flush(flush),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_ifid_instr(ifid_instr),
    .o_ifid_pc_plus4(ifid_pp4), .o_ifid_valid(ifid_valid), .o_misalign(misalign)
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BOOT_CYCLES(2)) dut_w (
    .i_clk(clk), .i_rst(w_rst), .i_next_pc(w_next_pc), .i_instr(w_instr),
    .i_stall(w_stall), .i_flush(w_flush),
    .o_pc(w_pc), .o_pc_plus4(w_pc_plus4), .o_ifid_instr(w_ifid_instr),
    .o_ifid_pc_plus4(w_ifid_pp4), .o_ifid_valid(w_ifid_valid), .o_misalign(w_misalign)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pp4;
    logic        exp_valid;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pp4, input logic e_valid, input logic e_mis);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, " ifid_instr"}, ifid_instr, e_instr);
    chk({tag, " ifid_pc_plus4"}, ifid_pp4, e_pp4);
    chk({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    chk({tag, " misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    $display("%s: pc=%h instr=%h pp4=%h valid=%0b mis=%0b", tag, pc, ifid_instr, ifid_pp4,
             ifid_valid, misalign);
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] np, input logic [31:0] ins);
    stall = s; flush = f; next_pc = np; instr = ins;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h2002_0005, 32'h0000_0004, 32'h2002_0005, 32'h0000_0004, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0008, 32'h1111_1111, 32'h0000_0008, 32'h1111_1111, 32'h0000_0008, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_000C, 32'h2222_2222, 32'h0000_0008, 32'h1111_1111, 32'h0000_0008, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_000C, 32'h2222_2222, 32'h0000_0008, 32'h1111_1111, 32'h0000_0008, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_000C, 32'h2222_2222, 32'h0000_0008, 32'h1111_1111, 32'h0000_0008, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_000C, 32'h3333_3333, 32'h0000_000C, 32'h3333_3333, 32'h0000_000C, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0044, 32'h4444_4444, 32'h0000_0044, 32'h4444_4444, 32'h0000_0044, 1'b1, 1'b0};
    // Stalled cycle with a misaligned target: PC does not update, so no trap.
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0042, 32'h5555_5555, 32'h0000_0044, 32'h4444_4444, 32'h0000_0044, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0042, 32'h5555_5555, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    w_rst = 1'b1; w_stall = 1'b0; w_flush = 1'b0; w_next_pc = 32'h0; w_instr = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Boot cycles ignore stall, flush and a misaligned target.
    drive(1'b1, 1'b1, 32'h0000_0042, 32'h9999_9999);
    @(posedge clk); #1;
    chk_all("boot1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("boot2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // First RUN edge is cycle 3.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].next_pc, vecs[i].instr);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pp4,
              vecs[i].exp_valid, vecs[i].exp_mis);
    end

    for (int i = 0; i < 10; i++) begin
      drive(i[0], i[1], 32'h0000_0048, 32'h6666_6666);
      @(posedge clk); #1;
      chk_all($sformatf("halt%0d", i), 32'h0000_0044, 32'h0, 32'h0, 1'b0, 1'b1);
    end

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all("halt_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset during a stall, mid-run.
    drive(1'b0, 1'b0, 32'h0000_0004, 32'h0);
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 32'h0000_0004, 32'h7777_7777);
    @(posedge clk); #1;
    chk_all("rerun", 32'h0000_0004, 32'h7777_7777, 32'h0000_0004, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h8888_8888);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all("stall_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Wrap-around instance.
    #1 w_rst = 1'b0;
    chk("wrap pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", w_pc_plus4, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap boot valid", {31'd0, w_ifid_valid}, 32'd0);
    w_next_pc = 32'h0000_0000; w_instr = 32'hABCD_0123;
    @(posedge clk); #1;
    chk("wrap next pc", w_pc, 32'h0000_0000);
    chk("wrap ifid_pc_plus4", w_ifid_pp4, 32'h0000_0000);
    chk("wrap ifid_instr", w_ifid_instr, 32'hABCD_0123);
    chk("wrap ifid_valid", {31'd0, w_ifid_valid}, 32'd1);
    chk("wrap misalign", {31'd0, w_misalign}, 32'd0);
    $display("wrap: pc=%h instr=%h pp4=%h valid=%0b", w_pc, w_ifid_instr, w_ifid_pp4, w_ifid_valid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
